// File: rtl/vga_scan_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v counters and registered sync/strobe decode.
// Define VGA_FRAME_CNT_EN to add a 16-bit frame counter output (frame_cnt).
module vga_scan_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        pix_en,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        video_on,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        line_start,
  output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

  // y is only 9 bits wide and both counters are 10 bits wide
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_scan_gen: CLK_DIV must be >= 1");
  end
  if (H_ACTIVE > 1023 || V_ACTIVE > 512) begin : g_bad_active
    $error("vga_scan_gen: H_ACTIVE must be <= 1023 and V_ACTIVE <= 512");
  end
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_scan_gen: H/V totals must fit a 10-bit counter");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       hcnt_q, hcnt_d;
  logic [9:0]       vcnt_q, vcnt_d;
  logic             pix_en_q, pix_en_d;
  logic [9:0]       x_q, x_d;
  logic [8:0]       y_q, y_d;
  logic             video_on_q, video_on_d;
  logic             hsync_n_q, hsync_n_d;
  logic             vsync_n_q, vsync_n_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic             tick;
  logic             vid;

  always_comb begin
    tick          = (div_q == DIV_LAST);
    div_d         = tick ? '0 : div_q + DIV_W'(1);
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    vid           = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    pix_en_d      = tick;
    x_d           = x_q;
    y_d           = y_q;
    video_on_d    = video_on_q;
    hsync_n_d     = hsync_n_q;
    vsync_n_d     = vsync_n_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (tick) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end

      // decode the pre-increment position so outputs line up with pix_en
      video_on_d    = vid;
      x_d           = vid ? hcnt_q : '0;
      y_d           = vid ? vcnt_q[8:0] : '0;
      hsync_n_d     = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
      vsync_n_d     = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
      line_start_d  = (hcnt_q == '0);
      frame_start_d = (hcnt_q == '0) && (vcnt_q == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q         <= '0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      pix_en_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      video_on_q    <= 1'b0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      pix_en_q      <= pix_en_d;
      x_q           <= x_d;
      y_q           <= y_d;
      video_on_q    <= video_on_d;
      hsync_n_q     <= hsync_n_d;
      vsync_n_q     <= vsync_n_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_en      = pix_en_q;
  assign x           = x_q;
  assign y           = y_q;
  assign video_on    = video_on_q;
  assign hsync_n     = hsync_n_q;
  assign vsync_n     = vsync_n_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // counts the registered strobe, so it steps one clk after frame_start is seen
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start_q) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: a reduced-raster instance checked pulse-by-pulse through a scoreboard,
// plus a default-timing instance checked against hand-computed vectors over its first line.
module tb_vga_scan_gen;

  localparam int DIV = 2;
  // reduced raster: 24 pixels x 11 lines
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic       vid;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } exp_t;

  typedef struct {
    int   idx;
    exp_t e;
  } dvec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_n_d = 1'b0;
  logic rst_s, rst_sd;

  logic       pix_en, video_on, hsync_n, vsync_n, line_start, frame_start;
  logic [9:0] x;
  logic [8:0] y;
  logic       d_pix_en, d_video_on, d_hsync_n, d_vsync_n, d_line_start, d_frame_start;
  logic [9:0] d_x;
  logic [8:0] d_y;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt, d_frame_cnt;
  logic [15:0] efc = '0;
`endif

  exp_t  q[$];
  dvec_t dq[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  vga_scan_gen #(
    .CLK_DIV(DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .reset_n(rst_n), .pix_en(pix_en), .x(x), .y(y), .video_on(video_on),
    .hsync_n(hsync_n), .vsync_n(vsync_n), .line_start(line_start), .frame_start(frame_start)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  vga_scan_gen dut_d (
    .clk(clk), .reset_n(rst_n_d), .pix_en(d_pix_en), .x(d_x), .y(d_y), .video_on(d_video_on),
    .hsync_n(d_hsync_n), .vsync_n(d_vsync_n), .line_start(d_line_start), .frame_start(d_frame_start)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(d_frame_cnt)
`endif
  );

  always @(posedge clk) begin
    rst_s  <= rst_n;
    rst_sd <= rst_n_d;
  end

  task automatic chk(input bit ok, input string name, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  function automatic exp_t mk(int xv, int yv, bit vid, bit hs, bit vs, bit ls, bit fs);
    exp_t e;
    e.x = 10'(xv); e.y = 9'(yv); e.vid = vid; e.hs = hs; e.vs = vs; e.ls = ls; e.fs = fs;
    return e;
  endfunction

  function automatic exp_t model(int h, int v);
    bit vid;
    vid = (h < HA) && (v < VA);
    return mk(vid ? h : 0, vid ? v : 0, vid,
              !(h >= HA + HF && h < HA + HF + HS),
              !(v >= VA + VF && v < VA + VF + VS),
              h == 0, h == 0 && v == 0);
  endfunction

  task automatic push_seq(input int n);
    int h = 0, v = 0;
    for (int i = 0; i < n; i++) begin
      q.push_back(model(h, v));
      h++;
      if (h == HT) begin
        h = 0;
        v = (v + 1) % VT;
      end
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    chk(q.size() == 0, name, $sformatf("pending=%0d required=0", q.size()));
  endtask

  task automatic push_d(input int idx, input exp_t e);
    dvec_t d;
    d.idx = idx;
    d.e = e;
    dq.push_back(d);
  endtask

  // stimulus
  initial begin
    push_d(0,   mk(0,   0, 1, 1, 1, 1, 1));
    push_d(639, mk(639, 0, 1, 1, 1, 0, 0));
    push_d(640, mk(0,   0, 0, 1, 1, 0, 0));
    push_d(655, mk(0,   0, 0, 1, 1, 0, 0));
    push_d(656, mk(0,   0, 0, 0, 1, 0, 0));
    push_d(751, mk(0,   0, 0, 0, 1, 0, 0));
    push_d(752, mk(0,   0, 0, 1, 1, 0, 0));
    push_d(800, mk(0,   1, 1, 1, 1, 1, 0));

    repeat (3) @(posedge clk);
    // two full frames, then stop at line 4 pixel 10 of the third
    push_seq(2 * HT * VT + 4 * HT + 11);
    #1;
    rst_n = 1'b1;
    rst_n_d = 1'b1;
    drain("seg1_drain");
    #1;
`ifdef VGA_FRAME_CNT_EN
    chk(frame_cnt === 16'd3, "frame_cnt_after_3", $sformatf("got=%0d required=3", frame_cnt));
`endif
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    push_seq(HT * VT + 20);
    #1;
    rst_n = 1'b1;
`ifdef VGA_FRAME_CNT_EN
    repeat (4) @(posedge clk);
    #1;
    force dut.frame_cnt_q = 16'hFFFF;
    efc = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.frame_cnt_q;
`endif
    drain("seg2_drain");
    #1;
`ifdef VGA_FRAME_CNT_EN
    chk(frame_cnt === 16'd0, "frame_cnt_wrap", $sformatf("got=%0d required=0", frame_cnt));
`endif
    rst_n = 1'b0;
    begin
      int n = 0;
      while (dq.size() != 0 && n < 4000) begin
        @(posedge clk);
        n++;
      end
    end
    chk(dq.size() == 0, "default_inst_drain", $sformatf("pending=%0d required=0", dq.size()));
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // monitor for the reduced-raster instance
  initial begin
    exp_t cur, last, e, rst_val;
    int gap = 0, hpos = 0, hs_cnt = 0, hs_first = -1, fpos = 0, vs_cnt = 0;
    bit line_ok = 0, frame_ok = 0;
    rst_val = mk(0, 0, 0, 1, 1, 0, 0);
    last = rst_val;
    @(posedge clk);
    forever begin
      @(negedge clk);
      cur = {x, y, video_on, hsync_n, vsync_n, line_start, frame_start};
      if (!rst_s) begin
        chk(pix_en === 1'b0 && cur === rst_val, "reset_values",
            $sformatf("pix_en=%b outs=%h required pix_en=0 outs=%h", pix_en, cur, rst_val));
        last = rst_val; gap = 0; line_ok = 0; frame_ok = 0;
`ifdef VGA_FRAME_CNT_EN
        chk(frame_cnt === 16'd0, "reset_frame_cnt", $sformatf("got=%0d required=0", frame_cnt));
        efc = '0;
`endif
      end else if (pix_en === 1'b1) begin
        chk(gap + 1 == DIV, "pix_en_period", $sformatf("got=%0d required=%0d", gap + 1, DIV));
        gap = 0;
        if (q.size() == 0) begin
          chk(1'b0, "unexpected_pix_en", $sformatf("outs=%h required no pulse", cur));
        end else begin
          e = q.pop_front();
          chk(cur === e, "pixel", $sformatf("got=%h required=%h", cur, e));
        end
        if (line_start === 1'b1) begin
          if (line_ok)
            chk(hs_cnt == HS && hs_first == HA + HF, "hsync_window",
                $sformatf("len=%0d start=%0d required len=3 start=18", hs_cnt, hs_first));
          line_ok = 1; hpos = 0; hs_cnt = 0; hs_first = -1;
        end
        if (hsync_n === 1'b0) begin
          if (hs_first < 0) hs_first = hpos;
          hs_cnt++;
        end
        hpos++;
        if (frame_start === 1'b1) begin
          if (frame_ok)
            chk(fpos == 264 && vs_cnt == 48, "frame_period_vsync",
                $sformatf("period=%0d vs_low=%0d required period=264 vs_low=48", fpos, vs_cnt));
          frame_ok = 1; fpos = 0; vs_cnt = 0;
        end
        if (vsync_n === 1'b0) vs_cnt++;
        fpos++;
        last = cur;
      end else begin
        gap++;
        chk(cur.x === last.x && cur.y === last.y && cur.vid === last.vid && cur.hs === last.hs &&
            cur.vs === last.vs && cur.ls === 1'b0 && cur.fs === 1'b0, "hold",
            $sformatf("got=%h required held=%h with strobes 0", cur, {last[23:2], 2'b00}));
      end
`ifdef VGA_FRAME_CNT_EN
      if (rst_s) begin
        chk(frame_cnt === efc, "frame_cnt", $sformatf("got=%0d required=%0d", frame_cnt, efc));
        if (frame_start === 1'b1) efc = efc + 16'd1;
      end
`endif
    end
  end

  // monitor for the default-timing instance
  initial begin
    exp_t cur;
    dvec_t d;
    int didx = 0, hs_cnt = 0, hs_first = -1;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (rst_sd && d_pix_en === 1'b1) begin
        cur = {d_x, d_y, d_video_on, d_hsync_n, d_vsync_n, d_line_start, d_frame_start};
        if (didx < 640)
          chk(d_x === 10'(didx) && d_video_on === 1'b1, "d_active_x",
              $sformatf("idx=%0d x=%0d vid=%b required x=%0d vid=1", didx, d_x, d_video_on, didx));
        if (didx < 800 && d_hsync_n === 1'b0) begin
          if (hs_first < 0) hs_first = didx;
          hs_cnt++;
        end
        if (didx == 800)
          chk(hs_cnt == 96 && hs_first == 656, "d_hsync_window",
              $sformatf("len=%0d start=%0d required len=96 start=656", hs_cnt, hs_first));
        if (dq.size() != 0 && dq[0].idx == didx) begin
          d = dq.pop_front();
          chk(cur === d.e, "d_vector", $sformatf("idx=%0d got=%h required=%h", didx, cur, d.e));
        end
        didx++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vga_scan_gen.md
Name: vga_scan_gen

Overview:
- Generates VGA raster timing and the current pixel coordinate for the display pipeline.
- Sits directly upstream of the board and sprite renderers, which consume x (10 b) and y (9 b) and decide per-pixel colour.
- Produces hsync_n/vsync_n for the DAC, a video_on qualifier, and line/frame strobes used by game logic to update once per frame.

Parameters:
- CLK_DIV, 2, system clocks per pixel (pixel enable period), must be >= 1
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, pixels
- H_SYNC, 96, horizontal sync width, pixels
- H_BP, 48, horizontal back porch, pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, lines
- V_SYNC, 2, vertical sync width, lines
- V_BP, 33, vertical back porch, lines

Ports:
- clk  input  1  system clock
- reset_n  input  1  reset, synchronous, active-low
- pix_en  output  1  one-clk pulse marking each pixel slot
- x  output  10  current column, 0..H_ACTIVE-1 when video_on, else 0
- y  output  9  current row, 0..V_ACTIVE-1 when video_on, else 0
- video_on  output  1  high inside the active region
- hsync_n  output  1  horizontal sync, active-low
- vsync_n  output  1  vertical sync, active-low
- line_start  output  1  one-clk pulse at h=0 of each line
- frame_start  output  1  one-clk pulse at h=0, v=0

Behaviour:
- Reset behaviour: one clock, reset synchronous and active-low on reset_n. While reset_n=0 at a clk edge:
  - div, hcnt and vcnt clear to 0.
  - pix_en, x, y, video_on, line_start and frame_start = 0.
  - hsync_n and vsync_n = 1.
  - A mid-frame reset restarts the raster at (0,0). The first frame_start appears at the first pix_en after release.
- Divider: div counts 0..CLK_DIV-1 and wraps.
  - Internal tick = (div == CLK_DIV-1).
  - pix_en is the registered tick, so it is high one clk per CLK_DIV clks.
  - CLK_DIV=1 gives pix_en constantly high after the first clk following reset release.
- Counters (advance only on tick):
  - hcnt is 10 b, 0..H_TOTAL-1, where H_TOTAL = sum of H_* = 800.
  - At hcnt = H_TOTAL-1: hcnt wraps to 0 and vcnt increments.
  - vcnt is 10 b, 0..V_TOTAL-1, where V_TOTAL = 525. At vcnt = V_TOTAL-1 together with the hcnt wrap, vcnt wraps to 0.
- Output decode: combinational from the counter state that is valid during the tick, then registered on the same edge as pix_en. All outputs are therefore mutually aligned and qualified by pix_en.
  - video_on = hcnt<H_ACTIVE && vcnt<V_ACTIVE.
  - x = video_on ? hcnt : 0.
  - y = video_on ? vcnt[8:0] : 0.
  - hsync_n = 0 for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vsync_n = 0 for V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491. It is asserted over whole lines.
  - line_start = (hcnt==0) on the tick.
  - frame_start = (hcnt==0 && vcnt==0) on the tick. frame_start implies line_start.
- Hold behaviour: between pix_en pulses, x, y, video_on, hsync_n and vsync_n hold their values. line_start and frame_start are 0.
- Latency: one clk from the tick to the outputs. Downstream logic samples on pix_en.
- Width rule: y is truncated to 9 b. This is legal because V_ACTIVE <= 512. Elaboration must error if H_ACTIVE>1023 or V_ACTIVE>512.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- When defined:
  - Adds output frame_cnt (16 b), reset to 0.
  - Increments by 1 on every clk in which frame_start is asserted.
  - Wraps 0xFFFF to 0.
  - Usable as an animation timebase (e.g. ghost blink).
- When undefined: the port and its register are absent. All other behaviour is identical.

Test Plan:
- reset_n=0 for 3 clks, then released:
  - pix_en pulses every 2nd clk.
  - The first pulse carries x=0, y=0, video_on=1, line_start=1, frame_start=1.
  - hsync_n=1 and vsync_n=1.
- One full line:
  - x counts 0..639 with video_on=1, then video_on=0 and x=0.
  - hsync_n is low for exactly 96 pix_en pulses, starting at pulse index 656.
  - The next line_start comes 800 pulses (1600 clks) later, with y=1.
- Frame boundary:
  - vsync_n is low for exactly 2 lines (1600 pulses), lines 490 and 491.
  - frame_start recurs after 420000 pulses (840000 clks).
  - Last active pixel x=639, y=479 has video_on=1; the next pulse has video_on=0.
- Reset mid-frame at line 300, pixel 200:
  - Outputs clear on the next edge.
  - After release, the first pix_en shows frame_start=1 and x=y=0.
  - No partial vsync is produced.
- CLK_DIV=1 build: pix_en stays high, and line period = 800 clks.
- VGA_FRAME_CNT_EN defined: after 3 frame_start pulses frame_cnt=3. With the counter preloaded to 0xFFFF via force, the next frame_start gives 0.
